// File: rtl/mem_stage.sv
// Memory stage: load/store over a req/gnt/rvld data-memory handshake with lane steering,
// load extension and misalignment traps. Define MEM_TIMEOUT_EN to abort accesses stuck in REQ/WAIT.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_alu_res,
  input  logic [31:0] EX_mem_din,
  input  logic        EX_vld,
  input  logic        EX_mem_rd,
  input  logic        EX_mem_wr,
  input  logic [1:0]  EX_mem_size,
  input  logic        EX_mem_uns,
  input  logic [4:0]  EX_rd_idx,
  output logic        MEM_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvld,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MEM_res,
  output logic [4:0]  MEM_rd_idx,
  output logic        MEM_vld,
  output logic        MEM_exc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [31:0] EXC_VAL = 32'hbaadbeef;

  function automatic logic mem_bad(input logic rd, input logic wr,
                                   input logic [1:0] size, input logic [1:0] a);
    logic b;
    b = (size == 2'b11) | ((size == 2'b01) & a[0]) |
        ((size == 2'b10) & (a != 2'b00)) | (rd & wr);
    return (rd | wr) & b;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  state_t state, state_nxt;

  logic        vld_p0;
  logic [31:0] addr_p0;
  logic [31:0] data_p0;
  logic        rd_p0;
  logic        wr_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [4:0]  rd_idx_p0;

  logic ex_go;
  logic mem_p0, bad_p0, ok_p0;
  logic req_live, done_st, done_ld, done, abort, load_en;
  logic tmo_hit;

  assign ex_go  = EX_vld & (EX_mem_rd | EX_mem_wr) &
                  ~mem_bad(EX_mem_rd, EX_mem_wr, EX_mem_size, EX_alu_res[1:0]);
  assign mem_p0 = rd_p0 | wr_p0;
  assign bad_p0 = mem_bad(rd_p0, wr_p0, size_p0, addr_p0[1:0]);
  assign ok_p0  = vld_p0 & mem_p0 & ~bad_p0;

  // A store completes on its grant; a load only on rvld seen in WAIT, never on the grant cycle.
  assign req_live = (state == REQ) & ~tmo_hit;
  assign done_st  = req_live & wr_p0 & dmem_gnt;
  assign done_ld  = (state == WAIT) & dmem_rvld;
  assign done     = done_st | done_ld;
  assign abort    = tmo_hit & ~done;

  assign MEM_stall = ok_p0 & ~done & ~abort;
  assign load_en   = ~MEM_stall;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (load_en & ex_go) begin
      tmo_cnt <= '0;
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic tmo_unused;

  assign tmo_unused = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // Stage p0: captured EX result; control fields reset, payload free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vld_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_en) vld_p0 <= EX_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      addr_p0   <= EX_alu_res;
      data_p0   <= EX_mem_din;
      rd_p0     <= EX_mem_rd;
      wr_p0     <= EX_mem_wr;
      size_p0   <= EX_mem_size;
      uns_p0    <= EX_mem_uns;
      rd_idx_p0 <= EX_rd_idx;
    end
  end

  always_comb begin
    state_nxt  = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'b0;
    dmem_be    = 4'b0;
    dmem_wdata = 32'b0;
    MEM_vld    = 1'b0;
    MEM_exc    = 1'b0;
    MEM_res    = 32'b0;
    MEM_rd_idx = 5'b0;

    // Any edge that loads p0 also picks the next state from what is being captured.
    if (load_en) begin
      state_nxt = ex_go ? REQ : IDLE;
    end else if (req_live && dmem_gnt) begin
      state_nxt = WAIT;
    end

    if (req_live) begin
      dmem_req   = 1'b1;
      dmem_we    = wr_p0;
      dmem_addr  = {addr_p0[31:2], 2'b00};
      dmem_be    = byte_en(size_p0, addr_p0[1:0]);
      dmem_wdata = store_lanes(size_p0, data_p0);
    end

    if (vld_p0 && !mem_p0) begin
      MEM_vld = 1'b1;
      MEM_res = addr_p0;
    end else if (vld_p0 && bad_p0) begin
      MEM_vld = 1'b1;
      MEM_exc = 1'b1;
      MEM_res = EXC_VAL;
    end else if (done_st) begin
      MEM_vld = 1'b1;
    end else if (done_ld) begin
      MEM_vld = 1'b1;
      MEM_res = load_fmt(dmem_rdata, addr_p0[1:0], size_p0, uns_p0);
    end else if (abort) begin
      MEM_vld = 1'b1;
      MEM_exc = 1'b1;
      MEM_res = EXC_VAL;
    end

    if (MEM_vld) MEM_rd_idx = rd_idx_p0;
  end

endmodule
